// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// master is the controller side; slave is the datapath side.
interface multicycle_controller_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ResultSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUControl;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [3:0] Flags;

  modport master (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Flags
  );

  modport slave (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Flags
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control FSM: sequences fetch/decode/execute/memory/writeback
// and owns the NZCV flag register with condition-code evaluation.
module multicycle_controller #(
  parameter logic [3:0] FLAGS_INIT = 4'b0000
) (
  input logic               CLK,
  input logic               RST,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb,
    StMemWrite, StExecuteR, StExecuteI, StAluWb, StBranch
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] flags_q;
  logic       cond_ex_q;

  logic [3:0] cmd;
  logic [1:0] alu_dec;
  logic       no_write, cmd_valid, arith, set_flags;
  logic       cond_pass;
  logic       rd_pc;
  logic       pc_write, mem_write, reg_write, ir_write;

  assign cmd   = bus.Funct[4:1];
  assign rd_pc = (bus.Rd == 4'd15);

  always_comb begin
    alu_dec   = 2'b00;
    no_write  = 1'b0;
    cmd_valid = 1'b1;
    arith     = 1'b0;
    case (cmd)
      4'b0100: begin alu_dec = 2'b00; arith = 1'b1; end
      4'b0010: begin alu_dec = 2'b01; arith = 1'b1; end
      4'b0000: alu_dec = 2'b10;
      4'b1100: alu_dec = 2'b11;
      4'b1010: begin alu_dec = 2'b01; arith = 1'b1; no_write = 1'b1; end
      default: begin no_write = 1'b1; cmd_valid = 1'b0; end
    endcase
  end

  // CMP always updates flags; unsupported commands never do.
  assign set_flags = cmd_valid & (bus.Funct[0] | (cmd == 4'b1010));

  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    cond_pass = 1'b0;
    case (bus.Cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = ~c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = c & ~z;
      4'b1001: cond_pass = ~c | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = ~z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StFetch;
      flags_q   <= FLAGS_INIT;
      cond_ex_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) cond_ex_q <= cond_pass;
      if ((state_q == StExecuteR || state_q == StExecuteI) && cond_ex_q && set_flags) begin
        flags_q[3:2] <= bus.ALUFlags[3:2];
        if (arith) flags_q[1:0] <= bus.ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    state_d        = StFetch;
    pc_write       = 1'b0;
    mem_write      = 1'b0;
    reg_write      = 1'b0;
    ir_write       = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ALUControl = 2'b00;
    unique case (state_q)
      StFetch: begin
        state_d       = StDecode;
        ir_write      = 1'b1;
        pc_write      = 1'b1;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      StDecode: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        case (bus.Op)
          2'b01:   state_d = StMemAdr;
          2'b00:   state_d = bus.Funct[5] ? StExecuteI : StExecuteR;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr: begin
        state_d     = bus.Funct[0] ? StMemRead : StMemWrite;
        bus.ALUSrcB = 2'b01;
      end
      StMemRead: begin
        state_d    = StMemWb;
        bus.AdrSrc = 1'b1;
      end
      StMemWb: begin
        bus.ResultSrc = 2'b01;
        reg_write     = cond_ex_q;
        pc_write      = cond_ex_q & rd_pc;
      end
      StMemWrite: begin
        bus.AdrSrc = 1'b1;
        mem_write  = cond_ex_q;
      end
      StExecuteR: begin
        state_d        = StAluWb;
        bus.ALUControl = alu_dec;
      end
      StExecuteI: begin
        state_d        = StAluWb;
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = alu_dec;
      end
      StAluWb: begin
        reg_write = cond_ex_q & ~no_write;
        pc_write  = cond_ex_q & rd_pc & ~no_write;
      end
      StBranch: begin
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        pc_write      = cond_ex_q;
      end
      default: state_d = StFetch;
    endcase
  end

  // Strobes are gated by reset so nothing writes while the async reset is held.
  assign bus.PCWrite  = pc_write & RST;
  assign bus.MemWrite = mem_write & RST;
  assign bus.RegWrite = reg_write & RST;
  assign bus.IRWrite  = ir_write & RST;
  assign bus.ImmSrc   = bus.Op;
  assign bus.RegSrc   = {bus.Op == 2'b01, bus.Op == 2'b10};
  assign bus.Flags    = flags_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: an instruction-level model predicts every
// cycle's outputs and one negedge process compares them.
module tb_multicycle_controller;

  logic CLK;
  logic RST;
  multicycle_controller_if bus ();

  multicycle_controller dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  logic        chk_en = 1'b0;
  logic [19:0] exp_v;
  string       tag_s = "idle";
  int          cyc_k = 0;
  logic [3:0]  flags_m = 4'b0000;

  logic [19:0] act;
  assign act = {bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
                bus.ImmSrc, bus.RegSrc, bus.Flags};

  always @(negedge CLK) begin
    if (chk_en) begin
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", tag_s, cyc_k, act, exp_v);
      end
    end
  end

  task automatic check(input string name, input logic [19:0] got, input logic [19:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Expected output vector; ImmSrc/RegSrc follow the current Op, Flags the model.
  function automatic logic [19:0] mk(input logic pcw, input logic memw, input logic regw,
                                     input logic irw, input logic adr, input logic [1:0] rs,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [1:0] alu);
    logic [1:0] op;
    op = bus.Op;
    return {pcw, memw, regw, irw, adr, rs, asa, asb, alu, op,
            op == 2'b01, op == 2'b10, flags_m};
  endfunction

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;            4'h1: return !z;
      4'h2: return cf;           4'h3: return !cf;
      4'h4: return n;            4'h5: return !n;
      4'h6: return v;            4'h7: return !v;
      4'h8: return cf && !z;     4'h9: return !cf || z;
      4'hA: return n == v;       4'hB: return n != v;
      4'hC: return !z && n == v; 4'hD: return z || n != v;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Runs one instruction from FETCH; rst_k >= 0 pulls reset mid-cycle at that step.
  task automatic run_instr(input string tag, input logic [3:0] c, input logic [1:0] op,
                           input logic [5:0] fn, input logic [3:0] rd,
                           input logic [3:0] af, input int rst_k);
    logic       ok, nw, valid, arith, upd, rd15;
    logic [1:0] alu;
    logic [3:0] cmd;
    int         len;
    bus.Cond = c; bus.Op = op; bus.Funct = fn; bus.Rd = rd; bus.ALUFlags = af;
    tag_s = tag;
    ok    = cond_ok(c, flags_m);
    rd15  = (rd == 4'd15);
    cmd   = fn[4:1];
    nw = 1'b0; valid = 1'b1; arith = 1'b0; alu = 2'b00;
    case (cmd)
      4'b0100: arith = 1'b1;
      4'b0010: begin alu = 2'b01; arith = 1'b1; end
      4'b0000: alu = 2'b10;
      4'b1100: alu = 2'b11;
      4'b1010: begin alu = 2'b01; arith = 1'b1; nw = 1'b1; end
      default: begin nw = 1'b1; valid = 1'b0; end
    endcase
    upd = ok && valid && (fn[0] || cmd == 4'b1010);
    case (op)
      2'b00:   len = 4;
      2'b01:   len = fn[0] ? 5 : 4;
      2'b10:   len = 3;
      default: len = 2;
    endcase
    chk_en = 1'b1;
    for (int k = 0; k < len; k++) begin
      cyc_k = k;
      if (k == 0)      exp_v = mk(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 2'b00);
      else if (k == 1) exp_v = mk(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00);
      else if (op == 2'b00) begin
        if (k == 2) exp_v = mk(0, 0, 0, 0, 0, 2'b00, 0, fn[5] ? 2'b01 : 2'b00, alu);
        else        exp_v = mk(ok && !nw && rd15, 0, ok && !nw, 0, 0, 2'b00, 0, 2'b00, 2'b00);
      end else if (op == 2'b01) begin
        if (k == 2)      exp_v = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00);
        else if (!fn[0]) exp_v = mk(0, ok, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00);
        else if (k == 3) exp_v = mk(0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00);
        else             exp_v = mk(ok && rd15, 0, ok, 0, 0, 2'b01, 0, 2'b00, 2'b00);
      end else begin
        exp_v = mk(ok, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00);
      end
      if (k == rst_k) begin
        @(negedge CLK);
        #2 RST = 1'b0;
        flags_m = 4'b0000;
        exp_v = mk(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00);
        #1;
        check({tag, "_memwrite_drop"}, {19'd0, bus.MemWrite}, 20'd0);
        check({tag, "_reset_vec"}, act, exp_v);
        @(posedge CLK);
        @(posedge CLK);
        #1 RST = 1'b1;
        return;
      end
      @(posedge CLK);
      #1;
      if (op == 2'b00 && k == 2 && upd) begin
        flags_m[3:2] = af[3:2];
        if (arith) flags_m[1:0] = af[1:0];
      end
    end
  endtask

  initial begin
    RST = 1'b0;
    bus.Cond = 4'hE; bus.Op = 2'b01; bus.Funct = 6'd0; bus.Rd = 4'd0; bus.ALUFlags = 4'd0;
    tag_s = "reset";
    exp_v = mk(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00);
    chk_en = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_flags", {16'd0, bus.Flags}, 20'd0);
    check("reset_strobes", {16'd0, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite}, 20'd0);
    RST = 1'b1;

    run_instr("adds",   4'hE, 2'b00, 6'b001001, 4'd1,  4'b0110, -1);
    check("flags_adds", {16'd0, bus.Flags}, 20'h00006);
    run_instr("cmp_z",  4'hE, 2'b00, 6'b010101, 4'd0,  4'b0100, -1);
    check("flags_cmp_z", {16'd0, bus.Flags}, 20'h00004);
    run_instr("beq_t",  4'h0, 2'b10, 6'b100000, 4'd0,  4'b0000, -1);
    run_instr("cmp_nz", 4'hE, 2'b00, 6'b010101, 4'd0,  4'b0000, -1);
    run_instr("beq_nt", 4'h0, 2'b10, 6'b100000, 4'd0,  4'b0000, -1);
    run_instr("ldr_pc", 4'hE, 2'b01, 6'b011001, 4'd15, 4'b0000, -1);
    run_instr("cmp_z2", 4'hE, 2'b00, 6'b010101, 4'd0,  4'b0100, -1);
    run_instr("strne",  4'h1, 2'b01, 6'b011000, 4'd2,  4'b1111, -1);
    check("flags_strne", {16'd0, bus.Flags}, 20'h00004);
    run_instr("subs",   4'hE, 2'b00, 6'b000101, 4'd4,  4'b0011, -1);
    run_instr("orrs",   4'hE, 2'b00, 6'b011001, 4'd5,  4'b1000, -1);
    check("flags_orrs", {16'd0, bus.Flags}, 20'h0000B);
    run_instr("andi_pc", 4'hE, 2'b00, 6'b100000, 4'd15, 4'b1111, -1);
    run_instr("eors",   4'hE, 2'b00, 6'b000011, 4'd6,  4'b0000, -1);
    check("flags_eors", {16'd0, bus.Flags}, 20'h0000B);
    run_instr("addeq_f", 4'h0, 2'b00, 6'b001001, 4'd7, 4'b0100, -1);
    run_instr("undef",  4'hE, 2'b11, 6'b000000, 4'd0,  4'b0000, -1);
    run_instr("str_rst", 4'hE, 2'b01, 6'b011000, 4'd3, 4'b0000, 3);
    check("flags_after_rst", {16'd0, bus.Flags}, 20'd0);
    run_instr("add_post", 4'hE, 2'b00, 6'b001000, 4'd2, 4'b1111, -1);

    chk_en = 1'b0;
    @(negedge CLK);
    check("end_in_fetch", {19'd0, bus.IRWrite}, 20'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- FSM control unit for the multicycle ARM-subset datapath.
- Decodes the latched instruction fields and sequences fetch/decode/execute/memory/writeback.
- Drives the register file's WE3 (RegWrite) and read/write address muxing (RegSrc), plus all other datapath enables and selects.
- Holds the NZCV flag register and evaluates condition codes.

Parameters:
FLAGS_INIT, 4'b0000, NZCV value loaded on reset ({N,Z,C,V}, N = bit 3).

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-low reset
Cond  input  4  instruction bits [31:28]
Op  input  2  instruction bits [27:26]
Funct  input  6  instruction bits [25:20] (I, cmd[3:0], S/L)
Rd  input  4  instruction bits [15:12]
ALUFlags  input  4  NZCV from ALU, current cycle
PCWrite  output  1  PC load enable
MemWrite  output  1  data memory write enable
RegWrite  output  1  register file WE3
IRWrite  output  1  instruction register load
AdrSrc  output  1  0 = PC, 1 = ALUOut as memory address
ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  output  1  0 = RD1, 1 = PC
ALUSrcB  output  2  00 RD2, 01 ExtImm, 10 constant 4
ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
ImmSrc  output  2  equals Op
RegSrc  output  2  [0] = (Op==10), [1] = (Op==01)
Flags  output  4  current NZCV register (debug/observe)

Behaviour:
- Reset (RST low, async): state <= FETCH, Flags <= FLAGS_INIT, CondExR <= 0. While RST is low, PCWrite, IRWrite, RegWrite and MemWrite are forced 0. Other outputs take their FETCH values.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: Op=01 -> MEMADR; Op=00 and Funct[5]=0 -> EXECUTER; Op=00 and Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> FETCH (undefined, no side effects).
  - MEMADR: Funct[0]=1 -> MEMREAD, else MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH. MEMWRITE -> FETCH.
  - EXECUTER/EXECUTEI -> ALUWB -> FETCH. BRANCH -> FETCH.
- Latency: data-processing 4 cycles, LDR 5, STR 4, B 3.
- Per-state outputs (unlisted = 0):
  - FETCH: IRWrite=1, PCWrite=1 (unconditional), ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=00.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01, ALUControl=00.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=CondExR; PCWrite=CondExR&(Rd==15).
  - MEMWRITE: AdrSrc=1, MemWrite=CondExR.
  - EXECUTER: ALUSrcB=00, ALUControl from cmd.
  - EXECUTEI: ALUSrcB=01, ALUControl from cmd.
  - ALUWB: ResultSrc=00, RegWrite=CondExR&~NoWrite; PCWrite=CondExR&(Rd==15)&~NoWrite.
  - BRANCH: ALUSrcB=01, ALUControl=00, ResultSrc=10, PCWrite=CondExR.
- cmd = Funct[4:1]:
  - 0100 ADD -> 00
  - 0010 SUB -> 01
  - 0000 AND -> 10
  - 1100 ORR -> 11
  - 1010 CMP -> 01 with NoWrite=1 and S forced to 1
  - any other cmd -> ALUControl=00, NoWrite=1, no flag update.
- Condition evaluation (combinational on Cond and the Flags register):
  - EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V
  - HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V)
  - 1110 true, 1111 false.
- CondExR is registered at the DECODE->next edge. All later gating uses CondExR, never live flags.
- Flag update on the rising edge leaving EXECUTER/EXECUTEI, only if CondExR and S:
  - N,Z <= ALUFlags[3:2] for all four ops and CMP.
  - C,V <= ALUFlags[1:0] only for ADD/SUB/CMP.
- Async reset mid-instruction aborts immediately: no write strobe is asserted, and the next instruction starts at FETCH after RST rises.

Test Plan:
- Reset: RST=0 for 2 cycles with Op=01 -> state FETCH, all four strobes 0, Flags=0000. Release -> PCWrite=1 and IRWrite=1 on the first cycle.
- ADDS R1,R2,R3 (Cond=1110, Op=00, Funct=001001, Rd=1), ALUFlags=0110 in EXECUTER -> RegWrite=1 only in cycle 4, Flags=0110 afterwards, back in FETCH at cycle 5.
- CMP with ALUFlags=0100, then BEQ (Cond=0000, Op=10) -> PCWrite=1 in BRANCH. Repeat with CMP ALUFlags=0000 -> PCWrite=0 in BRANCH, 3-cycle branch.
- LDR R15 (Op=01, Funct[0]=1, Rd=15, AL) -> AdrSrc=1 in MEMREAD; ResultSrc=01, RegWrite=1, PCWrite=1 in MEMWB; 5 cycles total.
- STRNE with Z=1 -> MemWrite stays 0 in MEMWRITE; Flags unchanged; 4 cycles.
- Pull RST low during MEMWRITE of an AL STR -> MemWrite drops to 0 in the same cycle, state FETCH, Flags=FLAGS_INIT.
